// File: rtl/cpu.sv
// cpu: 8-bit VeriRisc accumulator CPU with an internal 32x8 unified program/data memory.
// Latency: one instruction per 8 master_clk cycles; HLT freezes all state until rst_ goes low.
// No backpressure; optional simulation trace compiled only when CPU_TRACE_EN is defined.

module cpu_mem #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              master_clk,
  input  logic              wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] memory [0:2**AWIDTH-1];

  assign rdata = memory[addr];

  // synchronous write; contents are intentionally left out of reset
  always_ff @(posedge master_clk) begin
    if (wr) memory[addr] <= wdata;
  end
endmodule

module cpu #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              master_clk,
  input  logic              rst_,
  output logic              halt,
  output logic              load_ir,
  output logic [AWIDTH-1:0] pc_addr
);
  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  phase_t            phase;
  phase_t            phase_nxt;
  logic [DWIDTH-1:0] ir;
  logic [DWIDTH-1:0] ac;
  logic [DWIDTH-1:0] mem_rd;
  logic [DWIDTH-1:0] alu_out;
  logic [AWIDTH-1:0] addr;
  logic [2:0]        opcode;
  logic              fetch;
  logic              zero;
  logic              mem_wr;

  assign opcode    = ir[DWIDTH-1 -: 3];
  assign phase_nxt = phase_t'(phase + 3'd1);
  // first half of the sequence addresses the instruction, second half the operand
  assign fetch     = (phase < OP_ADDR);
  assign addr      = fetch ? pc_addr : ir[AWIDTH-1:0];
  assign zero      = (ac == '0);
  assign mem_wr    = !halt && (phase == STORE) && (opcode == OP_STO);

  cpu_mem #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) mem1 (
    .master_clk (master_clk),
    .wr         (mem_wr),
    .addr       (addr),
    .wdata      (ac),
    .rdata      (mem_rd)
  );

  // ALU result for the accumulator-writing opcodes; ADD wraps modulo 2**DWIDTH
  always_comb begin
    alu_out = ac;
    case (opcode)
      OP_ADD:  alu_out = ac + mem_rd;
      OP_AND:  alu_out = ac & mem_rd;
      OP_XOR:  alu_out = ac ^ mem_rd;
      OP_LDA:  alu_out = mem_rd;
      default: alu_out = ac;
    endcase
  end

  // phase sequencer and architectural state; everything freezes once halt is set
  always_ff @(posedge master_clk or negedge rst_) begin
    if (!rst_) begin
      phase   <= INST_ADDR;
      pc_addr <= '0;
      ac      <= '0;
      ir      <= '0;
      halt    <= 1'b0;
      load_ir <= 1'b0;
    end else if (!halt) begin
      phase   <= phase_nxt;
      load_ir <= (phase_nxt == INST_LOAD) || (phase_nxt == IDLE);
      case (phase)
        INST_LOAD: ir <= mem_rd;
        OP_ADDR: begin
          if (opcode == OP_HLT) halt <= 1'b1;
          else                  pc_addr <= pc_addr + 1'b1;
        end
        ALU_OP: begin
          if (opcode == OP_SKZ && zero) pc_addr <= pc_addr + 1'b1;
          else if (opcode == OP_JMP)    pc_addr <= ir[AWIDTH-1:0];
        end
        STORE: begin
          if (opcode == OP_ADD || opcode == OP_AND ||
              opcode == OP_XOR || opcode == OP_LDA) ac <= alu_out;
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_TRACE_EN
  function automatic string mnem(input logic [2:0] op);
    case (op)
      OP_HLT:  return "HLT";
      OP_SKZ:  return "SKZ";
      OP_ADD:  return "ADD";
      OP_AND:  return "AND";
      OP_XOR:  return "XOR";
      OP_LDA:  return "LDA";
      OP_STO:  return "STO";
      default: return "JMP";
    endcase
  endfunction

  // one trace line per instruction as it reaches operand-address phase
  always @(posedge master_clk) begin
    if (rst_ && !halt && phase == OP_ADDR)
      $display("pc=%02h ir=%02h %s ac=%02h", pc_addr, ir, mnem(opcode), ac);
  end

  // report the edge at which halt rises
  always @(posedge master_clk) begin
    if (rst_ && !halt && phase == OP_ADDR && opcode == OP_HLT)
      $display("HALT at %02h", pc_addr);
  end
`endif
endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed programs plus random memory images, scored against an ISA-level model.
// Stimulus pushes expected halt state into a queue; a monitor pops and compares when halt rises.
module tb_cpu;
  localparam int LIMIT = 200;

  typedef struct packed {
    logic [4:0]   pc;
    logic [7:0]   ac;
    logic [31:0]  cycles;
    logic [255:0] mem;
  } exp_t;

  logic       master_clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       halt;
  logic       load_ir;
  logic [4:0] pc_addr;

  cpu dut (
    .master_clk (master_clk),
    .rst_       (rst_),
    .halt       (halt),
    .load_ir    (load_ir),
    .pc_addr    (pc_addr)
  );

  always #5 master_clk = ~master_clk;

  exp_t       exp_q[$];
  exp_t       last_exp;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  logic [7:0] prog [32];
  logic [7:0] mm [32];
  bit         halt_q = 1'b0;

  // clock edges since reset release (edge 1 is the first rising edge with rst_ high)
  always @(posedge master_clk) begin
    if (!rst_) cyc = 0;
    else       cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] mem_now();
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = dut.mem1.memory[i];
    return v;
  endfunction

  function automatic logic [255:0] pack_prog();
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = prog[i];
    return v;
  endfunction

  function automatic logic [255:0] pack_mm();
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = mm[i];
    return v;
  endfunction

  // instruction-level interpreter over mm[]; one loop pass = one instruction
  task automatic model_run(output logic [4:0] pc_o, output logic [7:0] ac_o,
                           output int n, output bit halted);
    logic [4:0] pc;
    logic [7:0] ac;
    logic [7:0] ir;
    logic [7:0] m;
    pc = 5'd0; ac = 8'd0; n = 0; halted = 1'b0;
    while (!halted && n < LIMIT) begin
      ir = mm[pc];
      m  = mm[ir[4:0]];
      n++;
      case (ir[7:5])
        3'd0: halted = 1'b1;
        3'd1: pc = pc + ((ac == 8'd0) ? 5'd2 : 5'd1);
        3'd2: begin ac = ac + m; pc = pc + 5'd1; end
        3'd3: begin ac = ac & m; pc = pc + 5'd1; end
        3'd4: begin ac = ac ^ m; pc = pc + 5'd1; end
        3'd5: begin ac = m;      pc = pc + 5'd1; end
        3'd6: begin mm[ir[4:0]] = ac; pc = pc + 5'd1; end
        default: pc = ir[4:0];
      endcase
    end
    pc_o = pc;
    ac_o = ac;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
  endtask

  // monitor: on each rising halt, pop the oldest expectation and compare final state
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge master_clk);
      if (!rst_) begin
        halt_q = 1'b0;
      end else begin
        if (halt && !halt_q) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_halt: got halt at pc %0h expected no halt", pc_addr);
          end else begin
            e = exp_q.pop_front();
            chk("halt_pc",    pc_addr,  e.pc);
            chk("halt_ac",    dut.ac,   e.ac);
            chk("halt_cycle", cyc,      e.cycles);
            chk("final_mem",  mem_now(), e.mem);
          end
          done_cnt++;
        end
        halt_q = halt;
      end
    end
  end

  // reset, preload prog[], publish the model's expectation, release and wait for halt
  task automatic run_case(input bit timing);
    exp_t       e;
    int         n;
    bit         halted;
    logic [4:0] pc;
    logic [7:0] ac;
    int         start_done;
    rst_ = 1'b0;
    repeat (5) @(negedge master_clk);
    for (int i = 0; i < 32; i++) begin
      dut.mem1.memory[i] = prog[i];
      mm[i] = prog[i];
    end
    model_run(pc, ac, n, halted);
    e.pc     = pc;
    e.ac     = ac;
    e.cycles = 32'((n - 1) * 8 + 5);
    e.mem    = pack_mm();
    exp_q.push_back(e);
    last_exp = e;
    @(negedge master_clk);
    start_done = done_cnt;
    rst_ = 1'b1;
    #1;
    chk("rst_pc",      pc_addr,  5'd0);
    chk("rst_halt",    halt,     1'b0);
    chk("rst_load_ir", load_ir,  1'b0);
    chk("rst_ac",      dut.ac,   8'd0);
    chk("rst_mem",     mem_now(), pack_prog());
    for (int t = 0; t < LIMIT * 8 + 20 && done_cnt == start_done; t++) begin
      @(negedge master_clk);
      if (timing && cyc >= 1 && cyc <= 8) begin
        chk($sformatf("load_ir_c%0d", cyc), load_ir, (cyc == 2 || cyc == 3));
        if (cyc == 4) chk("pc_before_c5", pc_addr, 5'd0);
        if (cyc == 5) chk("pc_after_c5",  pc_addr, 5'd1);
        if (cyc == 8) chk("ac_after_c8",  dut.ac,  8'hA0);
      end
    end
    if (done_cnt == start_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL halt_timeout: got no halt expected halt at pc %0h", e.pc);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic gen_random();
    int         n;
    bit         halted;
    logic [4:0] p;
    logic [7:0] a;
    do begin
      for (int i = 0; i < 32; i++) begin
        prog[i] = 8'($urandom);
        mm[i]   = prog[i];
      end
      model_run(p, a, n, halted);
    end while (!halted || n < 4);
  endtask

  initial begin : stimulus
    int budget;

    // single instruction timing: LDA 00 then HLT
    clear_prog();
    prog[0] = 8'hA0;
    prog[1] = 8'h00;
    run_case(1'b1);

    // Fibonacci until the temp value reaches 0x90
    clear_prog();
    prog[5'h00] = 8'hE3; // JMP 03
    prog[5'h03] = 8'hBB; // LDA 1B
    prog[5'h04] = 8'hDC; // STO 1C
    prog[5'h05] = 8'h5A; // ADD 1A
    prog[5'h06] = 8'hDB; // STO 1B
    prog[5'h07] = 8'hBC; // LDA 1C
    prog[5'h08] = 8'hDA; // STO 1A
    prog[5'h09] = 8'h9D; // XOR 1D
    prog[5'h0A] = 8'h20; // SKZ
    prog[5'h0B] = 8'hE3; // JMP 03
    prog[5'h0C] = 8'h00; // HLT
    prog[5'h1A] = 8'h01;
    prog[5'h1B] = 8'h00;
    prog[5'h1D] = 8'h90;
    prog[5'h1F] = 8'h01;
    run_case(1'b0);
    chk("fib_pc",   pc_addr, 5'h0C);
    chk("fib_last", dut.mem1.memory[28], 8'h90);

    // ADD wraps modulo 256
    clear_prog();
    prog[0] = 8'hBE; // LDA 1E
    prog[1] = 8'h5F; // ADD 1F
    prog[2] = 8'hDD; // STO 1D
    prog[3] = 8'h00;
    prog[5'h1E] = 8'hFF;
    prog[5'h1F] = 8'h02;
    run_case(1'b0);
    chk("add_wrap_ac",  dut.ac, 8'h01);
    chk("add_wrap_mem", dut.mem1.memory[29], 8'h01);

    // SKZ taken and not taken, JMP to 1F and PC wrap from 1F to 00
    clear_prog();
    prog[0] = 8'h20; // SKZ
    prog[1] = 8'h00; // HLT
    prog[2] = 8'hFF; // JMP 1F
    prog[5'h1E] = 8'h07;
    prog[5'h1F] = 8'hBE; // LDA 1E
    run_case(1'b0);
    chk("wrap_pc", pc_addr, 5'h01);

    // reset during the STORE phase of a STO drops the write
    clear_prog();
    prog[0] = 8'hBE; // LDA 1E
    prog[1] = 8'hDD; // STO 1D
    prog[2] = 8'h00;
    prog[5'h1E] = 8'h55;
    rst_ = 1'b0;
    repeat (2) @(negedge master_clk);
    for (int i = 0; i < 32; i++) dut.mem1.memory[i] = prog[i];
    rst_ = 1'b1;
    budget = 0;
    while (cyc != 15 && budget < 100) begin
      @(negedge master_clk);
      budget++;
    end
    chk("sto_abort_reach", cyc, 15);
    rst_ = 1'b0;
    repeat (2) @(negedge master_clk);
    chk("sto_abort_mem", dut.mem1.memory[29], 8'h00);
    chk("sto_abort_pc",  pc_addr, 5'd0);

    // random memory images
    for (int r = 0; r < 20; r++) begin
      gen_random();
      run_case(1'b0);
    end

    // halt is sticky; reset clears it and leaves memory intact
    repeat (100) @(negedge master_clk);
    chk("sticky_halt", halt,    1'b1);
    chk("sticky_pc",   pc_addr, last_exp.pc);
    chk("sticky_mem",  mem_now(), last_exp.mem);
    rst_ = 1'b0;
    @(negedge master_clk);
    chk("clr_halt",    halt,    1'b0);
    chk("clr_pc",      pc_addr, 5'd0);
    chk("clr_load_ir", load_ir, 1'b0);
    chk("clr_mem",     mem_now(), last_exp.mem);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
